instr_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the 16-bit Harvard core. Fetches 32-bit instructions from instruction memory and decodes the opcode field. Sequences the register file, the ALU (add/sub/neg/mul/logic/barrel shifts) and data memory through fetch, decode, execute, memory and writeback phases. Traps on undefined opcodes.

---
 rtl/instr_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_instr_seq_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle control sequencer for the 16-bit Harvard core: fetch, decode, execute,
// memory and writeback phases, with a sticky trap on undefined opcodes.
module instr_seq_ctrl #(
  parameter int PC_W = 8,
  parameter int DA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [31:0]     imem_data,
  input  logic            imem_valid,
  output logic [4:0]      rf_ra1,
  output logic [4:0]      rf_ra2,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [1:0]      wb_sel,
  output logic [15:0]     imm,
  output logic [3:0]      alu_op,
  output logic            alu_start,
  input  logic            alu_done,
  output logic [DA_W-1:0] dmem_addr,
  output logic            dmem_rd,
  output logic            dmem_wr,
  input  logic            dmem_valid,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {CL_LDI, CL_MOV, CL_LD, CL_ST, CL_ALU, CL_ILL} iclass_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            alu_first_q, alu_first_d;

  logic [5:0]      opcode;
  iclass_t         iclass;
  logic [4:0]      dec_ra1, dec_ra2, dec_wa;
  logic [1:0]      dec_wb_sel;
  logic [15:0]     dec_imm;
  logic [3:0]      dec_alu_op;
  logic [DA_W-1:0] dec_daddr;
  logic            fields_en;

  assign opcode = ir_q[31:26];

  // Field decode is purely a function of IR; it only reaches the ports between DECODE and the next FETCH.
  always_comb begin
    iclass     = CL_ILL;
    dec_ra1    = '0;
    dec_ra2    = '0;
    dec_wa     = '0;
    dec_wb_sel = '0;
    dec_imm    = '0;
    dec_alu_op = '0;
    dec_daddr  = '0;
    if (opcode == 6'd0)       iclass = CL_LDI;
    else if (opcode == 6'd1)  iclass = CL_MOV;
    else if (opcode == 6'd2)  iclass = CL_LD;
    else if (opcode == 6'd3)  iclass = CL_ST;
    else if (opcode <= 6'd16) iclass = CL_ALU;

    if (iclass != CL_ILL) begin
      dec_ra1 = ir_q[4:0];
      dec_ra2 = ir_q[9:5];
      dec_imm = ir_q[15:0];
    end

    case (iclass)
      CL_LDI: begin
        dec_wa     = ir_q[25:21];
        dec_wb_sel = 2'd1;
      end
      CL_MOV: begin
        dec_wa     = ir_q[25:21];
        dec_wb_sel = 2'd3;
      end
      CL_LD: begin
        dec_wa     = ir_q[25:21];
        dec_wb_sel = 2'd2;
        dec_daddr  = DA_W'(ir_q[7:0]);
      end
      CL_ST: begin
        // Store data comes out of read port 2, so steer it to the Rsrc1 field.
        dec_ra2   = ir_q[4:0];
        dec_daddr = DA_W'(ir_q[25:18]);
      end
      CL_ALU: begin
        dec_wa     = ir_q[20:16];
        dec_wb_sel = 2'd0;
        dec_alu_op = 4'(opcode - 6'd4);
      end
      default: ;
    endcase
  end

  assign fields_en = !rst && (state_q inside {DECODE, EXEC, MEM, WB});
  assign imem_addr = pc_q;
  assign rf_ra1    = fields_en ? dec_ra1    : '0;
  assign rf_ra2    = fields_en ? dec_ra2    : '0;
  assign rf_wa     = fields_en ? dec_wa     : '0;
  assign wb_sel    = fields_en ? dec_wb_sel : '0;
  assign imm       = fields_en ? dec_imm    : '0;
  assign alu_op    = fields_en ? dec_alu_op : '0;
  assign dmem_addr = fields_en ? dec_daddr  : '0;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    alu_first_d = 1'b0;
    imem_rd     = 1'b0;
    alu_start   = 1'b0;
    dmem_rd     = 1'b0;
    dmem_wr     = 1'b0;
    rf_we       = 1'b0;
    illegal     = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (run) begin
          imem_rd = 1'b1;
          busy    = 1'b1;
          if (imem_valid) begin
            ir_d    = imem_data;
            pc_d    = pc_q + PC_W'(1);
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        busy = 1'b1;
        case (iclass)
          CL_ALU: begin
            state_d     = EXEC;
            alu_first_d = 1'b1;
          end
          CL_LD, CL_ST:   state_d = MEM;
          CL_LDI, CL_MOV: state_d = WB;
          default:        state_d = TRAP;
        endcase
      end
      EXEC: begin
        // A done seen in the launch cycle belongs to no operation of ours.
        busy      = 1'b1;
        alu_start = alu_first_q;
        if (!alu_first_q && alu_done) state_d = WB;
      end
      MEM: begin
        busy    = 1'b1;
        dmem_rd = (iclass == CL_LD);
        dmem_wr = (iclass == CL_ST);
        if (dmem_valid) state_d = (iclass == CL_LD) ? WB : FETCH;
      end
      WB: begin
        busy    = 1'b1;
        rf_we   = 1'b1;
        state_d = FETCH;
      end
      TRAP: illegal = 1'b1;
      default: state_d = FETCH;
    endcase

    if (rst) begin
      imem_rd   = 1'b0;
      alu_start = 1'b0;
      dmem_rd   = 1'b0;
      dmem_wr   = 1'b0;
      rf_we     = 1'b0;
      illegal   = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      alu_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      alu_first_q <= alu_first_d;
    end
  end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboard bench for instr_seq_ctrl: behavioural imem/dmem/ALU responders and an
// event monitor that pops expected writebacks, ALU launches and data accesses.
module tb_instr_seq_ctrl;
  localparam int PC_W = 8;
  localparam int DA_W = 8;

  logic            clk;
  logic            rst;
  logic            run;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic [31:0]     imem_data;
  logic            imem_valid;
  logic [4:0]      rf_ra1, rf_ra2, rf_wa;
  logic            rf_we;
  logic [1:0]      wb_sel;
  logic [15:0]     imm;
  logic [3:0]      alu_op;
  logic            alu_start, alu_done;
  logic [DA_W-1:0] dmem_addr;
  logic            dmem_rd, dmem_wr, dmem_valid;
  logic            illegal, busy;

  instr_seq_ctrl #(.PC_W(PC_W), .DA_W(DA_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data), .imem_valid(imem_valid),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_we(rf_we), .rf_wa(rf_wa), .wb_sel(wb_sel),
    .imm(imm), .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_valid(dmem_valid),
    .illegal(illegal), .busy(busy)
  );

  // kind: 0 writeback(wa,wb_sel,imm), 1 ALU launch(op,wa), 2 load(addr,wa,wb_sel), 3 store(addr,ra2)
  typedef struct {int kind; int a; int b; int c;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wb_cnt = 0, start_cnt = 0, mem_cnt = 0;
  int we_cyc = 0, start_cyc = 0, fetch_cyc = 0, fetch_addr = 0;
  int mem_run = 0, last_mem_len = 0;
  int imem_wait = 0, alu_delay = 3;
  logic alu_early = 1'b1;
  logic [31:0] imem [256];
  int dwait [256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void pushExp(input int kind, input int a, input int b, input int c);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    sb.push_back(e);
  endfunction

  task automatic popEvent(input int kind, input int a, input int b, input int c);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("unexpected_event", 64'(kind + 1), 64'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("evt_kind", 64'(kind), 64'(e.kind));
      checkOutput("evt_a", 64'(a), 64'(e.a));
      checkOutput("evt_b", 64'(b), 64'(e.b));
      checkOutput("evt_c", 64'(c), 64'(e.c));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_v, input logic run_v);
    rst = rst_v;
    run = run_v;
  endtask

  task automatic waitWb(input int target, input int bound, input string tag);
    int k = 0;
    while (wb_cnt < target && k < bound) begin
      tick();
      k++;
    end
    checkOutput(tag, 64'(wb_cnt >= target), 64'd1);
  endtask

  // Event monitor: samples on the falling edge, away from the state update.
  initial begin
    logic prev_imem_rd, prev_mem;
    prev_imem_rd = 1'b0;
    prev_mem = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_rd && !prev_imem_rd) begin
          fetch_cyc = cyc;
          fetch_addr = int'(imem_addr);
        end
        if (rf_we) begin
          we_cyc = cyc;
          wb_cnt++;
          popEvent(0, int'(rf_wa), int'(wb_sel), int'(imm));
        end
        if (alu_start) begin
          start_cyc = cyc;
          start_cnt++;
          popEvent(1, int'(alu_op), int'(rf_wa), 0);
        end
        if ((dmem_rd || dmem_wr) && !prev_mem) begin
          mem_cnt++;
          popEvent(dmem_rd ? 2 : 3, int'(dmem_addr),
                   dmem_rd ? int'(rf_wa) : int'(rf_ra2), dmem_rd ? int'(wb_sel) : 0);
        end
        if (imem_rd || dmem_rd || dmem_wr || alu_start || rf_we)
          checkOutput("strobe_exclusive",
                      64'($countones({imem_rd, dmem_rd, dmem_wr, alu_start, rf_we})), 64'd1);
      end
      if (dmem_rd || dmem_wr) mem_run++;
      else if (mem_run != 0) begin
        last_mem_len = mem_run;
        mem_run = 0;
      end
      prev_imem_rd = imem_rd;
      prev_mem = dmem_rd || dmem_wr;
    end
  end

  // Instruction memory: answers after imem_wait stall cycles.
  initial begin
    int iw;
    iw = 0;
    imem_valid = 1'b0;
    imem_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (imem_rd && !rst) begin
        if (iw >= imem_wait) begin
          imem_valid = 1'b1;
          imem_data = imem[imem_addr];
          iw = 0;
        end else begin
          imem_valid = 1'b0;
          iw++;
        end
      end else begin
        imem_valid = 1'b0;
        iw = 0;
      end
    end
  end

  // Data memory: per-address stall count.
  initial begin
    int dw;
    dw = 0;
    dmem_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if ((dmem_rd || dmem_wr) && !rst) begin
        if (dw >= dwait[dmem_addr]) begin
          dmem_valid = 1'b1;
          dw = 0;
        end else begin
          dmem_valid = 1'b0;
          dw++;
        end
      end else begin
        dmem_valid = 1'b0;
        dw = 0;
      end
    end
  end

  // ALU: optional spurious done in the launch cycle, real done alu_delay cycles later.
  initial begin
    int ak;
    logic active;
    ak = 0;
    active = 1'b0;
    alu_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (alu_start) begin
        ak = 0;
        active = 1'b1;
        alu_done = alu_early;
      end else if (active) begin
        ak++;
        alu_done = (ak == alu_delay);
        if (ak > alu_delay) active = 1'b0;
      end else begin
        alu_done = 1'b0;
      end
      if (rst) begin
        active = 1'b0;
        alu_done = 1'b0;
      end
    end
  end

  initial begin
    int base, cnt, lost, start0, k, trap_cyc;
    logic [31:0] w;
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      dwait[i] = 0;
    end
    dwait[8'h7F] = 2;
    imem[0] = 32'h00A01234;
    imem[1] = 32'h10620041;
    imem[2] = 32'h0820007F;
    imem[3] = 32'h0C1C0003;
    imem[4] = 32'h44000000;
    tick();
    tick();
    checkOutput("reset_outputs",
                64'({imem_addr, imem_rd, rf_ra1, rf_ra2, rf_we, rf_wa, wb_sel, imm, alu_op,
                     alu_start, dmem_addr, dmem_rd, dmem_wr, illegal, busy}), 64'd0);

    pushExp(0, 5, 1, 'h1234);
    pushExp(1, 0, 2, 0);
    pushExp(0, 2, 0, 'h0041);
    pushExp(2, 'h7F, 1, 2);
    pushExp(0, 1, 2, 'h007F);
    pushExp(3, 'h07, 3, 0);
    applyStimulus(1'b0, 1'b1);

    waitWb(1, 20, "wait_ldi");
    checkOutput("ldi_latency", 64'(we_cyc - fetch_cyc), 64'd2);
    checkOutput("ldi_fetch_addr", 64'(fetch_addr), 64'd0);
    checkOutput("pc_after_ldi", 64'(imem_addr), 64'd1);

    waitWb(2, 40, "wait_add");
    checkOutput("add_start_to_we", 64'(we_cyc - start_cyc), 64'd4);
    checkOutput("add_start_pulses", 64'(start_cnt), 64'd1);

    waitWb(3, 40, "wait_ld");
    checkOutput("ld_rd_cycles", 64'(last_mem_len), 64'd3);

    k = 0;
    while (!illegal && k < 40) begin
      tick();
      k++;
    end
    trap_cyc = cyc;
    checkOutput("trap_seen", 64'(illegal), 64'd1);
    checkOutput("trap_latency", 64'(trap_cyc - fetch_cyc), 64'd2);
    checkOutput("st_wr_cycles", 64'(last_mem_len), 64'd1);
    checkOutput("st_events", 64'(mem_cnt), 64'd2);
    checkOutput("st_no_wb", 64'(wb_cnt), 64'd3);
    checkOutput("trap_busy", 64'(busy), 64'd0);

    cnt = 0;
    lost = 0;
    repeat (20) begin
      tick();
      if (imem_rd) cnt++;
      if (!illegal) lost++;
    end
    checkOutput("trap_no_fetch", 64'(cnt), 64'd0);
    checkOutput("trap_sticky", 64'(lost), 64'd0);

    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("trap_cleared", 64'(illegal), 64'd0);
    checkOutput("pc_reset_after_trap", 64'(imem_addr), 64'd0);

    base = wb_cnt;
    for (int i = 0; i < 256; i++) begin
      w = {6'd1, i[4:0], 5'd0, i[15:0]};
      imem[i] = w;
      pushExp(0, i % 32, 3, i);
    end
    applyStimulus(1'b0, 1'b1);
    waitWb(base + 256, 1000, "wait_wrap");
    applyStimulus(1'b0, 1'b0);
    checkOutput("pc_wrap", 64'(imem_addr), 64'd0);

    cnt = 0;
    lost = 0;
    repeat (5) begin
      tick();
      if (imem_rd) cnt++;
      if (busy) lost++;
    end
    checkOutput("run_low_no_fetch", 64'(cnt), 64'd0);
    checkOutput("run_low_idle", 64'(lost), 64'd0);
    checkOutput("last_fetch_addr", 64'(fetch_addr), 64'hFF);

    imem[0] = {6'd0, 5'd7, 5'd0, 16'hBEEF};
    imem[1] = {6'd5, 5'd0, 5'd9, 16'h0000};
    pushExp(0, 7, 1, 'hBEEF);
    pushExp(1, 1, 9, 0);
    imem_wait = 2;
    alu_delay = 1000;
    alu_early = 1'b0;
    applyStimulus(1'b0, 1'b1);
    waitWb(base + 257, 30, "wait_ldi_after_wrap");
    checkOutput("refetch_addr", 64'(fetch_addr), 64'd0);

    start0 = start_cnt;
    k = 0;
    while (start_cnt == start0 && k < 30) begin
      tick();
      k++;
    end
    checkOutput("sub_started", 64'(start_cnt), 64'(start0 + 1));
    checkOutput("sub_fetch_to_start", 64'(start_cyc - fetch_cyc), 64'd4);
    repeat (3) tick();
    checkOutput("exec_busy", 64'(busy), 64'd1);

    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("rst_exec_pc", 64'(imem_addr), 64'd0);
    checkOutput("rst_exec_alu_start", 64'(alu_start), 64'd0);
    checkOutput("rst_exec_busy", 64'(busy), 64'd0);
    checkOutput("rst_exec_imem_rd", 64'(imem_rd), 64'd0);

    applyStimulus(1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("idle_after_rst", 64'(busy), 64'd0);
    checkOutput("no_late_start", 64'(start_cnt), 64'(start0 + 1));
    checkOutput("no_late_wb", 64'(wb_cnt), 64'(base + 257));
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
